rx_matched_filter: RTL and testbench

//  Receive-side matched filter for the TX pulse-shaping filter: 65-tap symmetric FIR

---
 rtl/rx_filter_pkg.sv | 44 ++++
 rtl/rx_matched_filter_coef.sv | 20 ++
 rtl/rx_matched_filter.sv | 146 ++++++++++++++
 tb/tb_rx_matched_filter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_filter_pkg : shared constants, coefficients and state type for the RX   |
// |                 matched filter                                             |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package rx_filter_pkg;

    localparam int NTAPS = 65;
    localparam int NHALF = 33;
    localparam int DW    = 16;
    localparam int FRAC  = 13;
    localparam int ACCW  = 39;

    // Unique half of the symmetric Q2.13 pulse, outer edge first, centre last.
    localparam logic signed [DW-1:0] COEF [0:NHALF-1] = '{
        16'sh0012, 16'sh0025, 16'sh0031, 16'sh0030, 16'sh0022, 16'sh0008,
        16'shFFEE, 16'sh0000, 16'shFFC0, 16'shFF9E, 16'shFF8B, 16'shFF90,
        16'shFFB2, 16'shFFF0, 16'sh0030, 16'sh0060, 16'sh0030, 16'sh0000,
        16'shFFB0, 16'shFF50, 16'shFF00, 16'shFEE0, 16'shFF00, 16'shFF80,
        16'sh0060, 16'sh0200, 16'sh0420, 16'sh0680, 16'sh08C0, 16'sh0B80,
        16'sh0E00, 16'sh0FC0, 16'sh10E0
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Arithmetic shift down to Q2.13 and clamp to the 16-bit signed range.
    function automatic logic [DW-1:0] sat16(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] s;
        s = a >>> FRAC;
        if ((&s[ACCW-1:DW-1]) || !(|s[ACCW-1:DW-1]))
            return s[DW-1:0];
        else if (s[ACCW-1])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_matched_filter_coef.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_coef_rom : combinational tap-index to coefficient lookup                |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module rx_coef_rom
    import rx_filter_pkg::*;
(
    input  logic        [5:0]    k,
    output logic signed [DW-1:0] coef
);

    always_comb begin
        coef = '0;
        if (k <= 6'd32)
            coef = COEF[k];
    end

endmodule
`default_nettype wire

// File: rtl/rx_matched_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_matched_filter : 65-tap symmetric folded-MAC RX matched filter with     |
// |                     symbol-centre strobe; RX_SLICER_EN adds sym_bit        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module rx_matched_filter
    import rx_filter_pkg::*;
#(
    parameter int SPS       = 8,
    parameter int SYM_PHASE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_sample,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_sample,
    output logic          out_valid,
    output logic          sym_strobe
`ifdef RX_SLICER_EN
    ,
    output logic          sym_bit
`endif
);

    localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;

    state_t                  r_state;
    state_t                  w_next;
    logic signed [DW-1:0]    r_x [0:NTAPS-1];
    logic signed [ACCW-1:0]  r_acc;
    logic        [5:0]       r_k;
    logic        [PW-1:0]    r_phase;
    logic        [DW-1:0]    r_out_sample;

    logic        [6:0]       w_kidx;
    logic        [6:0]       w_kmir;
    logic signed [DW-1:0]    w_xa;
    logic signed [DW-1:0]    w_xb;
    logic signed [DW:0]      w_pre;
    logic signed [DW-1:0]    w_coef;
    logic signed [32:0]      w_prod;
    logic signed [ACCW-1:0]  w_acc_next;
    logic                    w_last;
    logic                    w_phase_hit;

    rx_coef_rom u_coef_rom (
        .k    (r_k),
        .coef (w_coef)
    );

    // Folded pair x[k] + x[64-k]; the centre tap has no partner.
    assign w_last      = (r_k == 6'd32);
    assign w_kidx      = {1'b0, r_k};
    assign w_kmir      = 7'd64 - w_kidx;
    assign w_xa        = r_x[w_kidx];
    assign w_xb        = w_last ? '0 : r_x[w_kmir];
    assign w_pre       = {w_xa[DW-1], w_xa} + {w_xb[DW-1], w_xb};
    assign w_prod      = {{16{w_pre[DW]}}, w_pre} * {{17{w_coef[DW-1]}}, w_coef};
    assign w_acc_next  = r_acc + {{(ACCW-33){w_prod[32]}}, w_prod};
    assign w_phase_hit = (r_phase == PW'(SYM_PHASE));
    assign out_sample  = r_out_sample;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = MAC;
            MAC:     if (w_last)   w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        sym_strobe = 1'b0;
        case (r_state)
            IDLE: in_ready = 1'b1;
            OUT: begin
                out_valid  = 1'b1;
                sym_strobe = w_phase_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++)
                r_x[i] <= '0;
            r_acc        <= '0;
            r_k          <= '0;
            r_phase      <= '0;
            r_out_sample <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = NTAPS-1; i > 0; i--)
                            r_x[i] <= r_x[i-1];
                        r_x[0] <= in_sample;
                        r_acc  <= '0;
                        r_k    <= '0;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + 6'd1;
                    // Register the result with the final product folded in, so it is ready in OUT.
                    if (w_last)
                        r_out_sample <= sat16(w_acc_next);
                end
                OUT: begin
                    if (r_phase == PW'(SPS-1))
                        r_phase <= '0;
                    else
                        r_phase <= r_phase + PW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef RX_SLICER_EN
    logic r_sym_bit;
    assign sym_bit = r_sym_bit;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_sym_bit <= 1'b0;
        else if (r_state == OUT && w_phase_hit)
            r_sym_bit <= ~r_out_sample[DW-1];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_matched_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rx_matched_filter : directed self-checking bench for rx_matched_filter  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_rx_matched_filter;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_sample;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        sym_strobe;
`ifdef RX_SLICER_EN
    logic        sym_bit;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [15:0] ctab [0:32] = '{
        16'h0012, 16'h0025, 16'h0031, 16'h0030, 16'h0022, 16'h0008,
        16'hFFEE, 16'h0000, 16'hFFC0, 16'hFF9E, 16'hFF8B, 16'hFF90,
        16'hFFB2, 16'hFFF0, 16'h0030, 16'h0060, 16'h0030, 16'h0000,
        16'hFFB0, 16'hFF50, 16'hFF00, 16'hFEE0, 16'hFF00, 16'hFF80,
        16'h0060, 16'h0200, 16'h0420, 16'h0680, 16'h08C0, 16'h0B80,
        16'h0E00, 16'h0FC0, 16'h10E0
    };

    rx_matched_filter #(.SPS(8), .SYM_PHASE(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .sym_strobe (sym_strobe)
`ifdef RX_SLICER_EN
        ,
        .sym_bit    (sym_bit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] cfull(input int j);
        return (j <= 32) ? ctab[j] : ctab[64-j];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offer one sample, then wait for its output pulse; returns value, strobe and latency.
    task automatic feed(input logic [15:0] v, output logic [15:0] o,
                        output logic strb, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b1;
        in_sample = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            vectors++;
            errors++;
            $display("FAIL feed_timeout: out_valid=0 after %0d cycles, required 1 within 34", lat);
        end
        o    = out_sample;
        strb = sym_strobe;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0 || sym_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: out_valid=%b sym_strobe=%b, required 0 0", out_valid, sym_strobe);
        end
        vectors++;
        if (out_sample !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out_sample: got %h, required 0000", out_sample);
        end
`ifdef RX_SLICER_EN
        vectors++;
        if (sym_bit !== 1'b0) begin
            errors++;
            $display("FAIL reset_sym_bit: got %b, required 0", sym_bit);
        end
`endif
    endtask

    task automatic test_impulse();
        logic [15:0] o;
        logic        s;
        int          lat;
        for (int n = 0; n < 65; n++) begin
            feed((n == 0) ? 16'h2000 : 16'h0000, o, s, lat);
            vectors++;
            if (o !== cfull(n)) begin
                errors++;
                $display("FAIL impulse_out%0d: got %h, required %h", n, o, cfull(n));
            end
            if (n == 0) begin
                vectors++;
                if (lat !== 34) begin
                    errors++;
                    $display("FAIL impulse_latency: got %0d cycles, required 34", lat);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] o;
        logic        s;
        int          lat;
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < 65; j++) begin
                logic neg;
                neg = cfull(j) >= 16'h8000;
                if (pass == 0)
                    feed(neg ? 16'h8000 : 16'h7FFF, o, s, lat);
                else
                    feed(neg ? 16'h7FFF : 16'h8000, o, s, lat);
            end
            vectors++;
            if (o !== ((pass == 0) ? 16'h7FFF : 16'h8000)) begin
                errors++;
                $display("FAIL saturation_pass%0d: got %h, required %h", pass, o,
                         (pass == 0) ? 16'h7FFF : 16'h8000);
            end
        end
    endtask

    task automatic test_back_to_back();
        int xfer [0:4];
        int outc [0:4];
        int nx;
        int no;
        int budget;
        nx = 0;
        no = 0;
        budget = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = 16'h0100;
        while (no < 5 && budget < 400) begin
            if (nx == 5) in_valid = 1'b0;
            if (out_valid && no < 5) begin
                outc[no] = cyc + 1;
                no++;
            end
            if (in_ready && in_valid && nx < 5) begin
                xfer[nx] = cyc + 1;
                nx++;
                in_sample = 16'h0100 + 16'(nx);
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        vectors++;
        if (nx !== 5 || no !== 5) begin
            errors++;
            $display("FAIL b2b_counts: transfers=%0d outputs=%0d, required 5 5", nx, no);
        end else begin
            for (int i = 1; i < 5; i++) begin
                vectors++;
                if (xfer[i] - xfer[i-1] !== 35) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d, required 35", i, xfer[i] - xfer[i-1]);
                end
            end
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (outc[i] - xfer[i] !== 34) begin
                    errors++;
                    $display("FAIL b2b_latency%0d: got %0d, required 34", i, outc[i] - xfer[i]);
                end
            end
        end
    endtask

    task automatic test_sym_strobe();
        logic [15:0] o;
        logic        s;
        int          lat;
        do_reset();
        for (int n = 0; n < 24; n++) begin
            feed(16'(n * 16), o, s, lat);
            vectors++;
            if (s !== (n == 3 || n == 11 || n == 19)) begin
                errors++;
                $display("FAIL strobe_out%0d: got %b, required %b", n, s, (n == 3 || n == 11 || n == 19));
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        int seen;
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        in_valid  = 1'b1;
        in_sample = 16'h2000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midmac_in_ready: got %b, required 1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midmac_no_output: got %0d pulses, required 0", seen);
        end
        test_impulse();
    endtask

`ifdef RX_SLICER_EN
    task automatic test_slicer();
        logic [11:0] syms;
        logic [15:0] o;
        logic        s;
        int          lat;
        syms = 12'b1011_0010_1101;
        do_reset();
        for (int n = 0; n < 124; n++) begin
            logic [15:0] v;
            v = 16'h0000;
            if (n % 8 == 3 && n / 8 < 12)
                v = syms[n/8] ? 16'h2000 : 16'hE000;
            feed(v, o, s, lat);
            if (n >= 35 && (n - 35) % 8 == 0) begin
                @(negedge clk);
                vectors++;
                if (sym_bit !== syms[(n-35)/8]) begin
                    errors++;
                    $display("FAIL slicer_sym%0d: got %b, required %b", (n-35)/8, sym_bit, syms[(n-35)/8]);
                end
            end
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sample = 16'h0000;
        test_reset();
        test_impulse();
        test_saturation();
        test_back_to_back();
        test_sym_strobe();
        test_reset_mid_mac();
`ifdef RX_SLICER_EN
        test_slicer();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
